// File: rtl/psg_bus_master_if.sv
// Request/response and PSG bus signals of psg_bus_master, grouped so the
// sequencer side and the PSG side can be wired as one bundle.
interface psg_bus_master_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [3:0] req_addr;
    logic [7:0] req_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       BDIR;
    logic       BC;
    logic [7:0] DA_out;
    logic [7:0] DA_in;
    logic       busy;

    // Bus master (the controller itself)
    modport master (
        input  req_valid, req_write, req_addr, req_data, DA_in,
        output req_ready, rsp_valid, rsp_data, BDIR, BC, DA_out, busy
    );

    // Sequencer plus PSG as seen from the outside
    modport slave (
        output req_valid, req_write, req_addr, req_data, DA_in,
        input  req_ready, rsp_valid, rsp_data, BDIR, BC, DA_out, busy
    );
endinterface

// File: rtl/psg_bus_master.sv
// AY-3-8912 style PSG bus initiator: buffers register write/read requests in a
// small FIFO and plays them out as latch-address / write / read bus cycles whose
// phase lengths are counted in PSG clock-enable ticks.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | bus inactive, pops the next request when the FIFO has one
// ADDR     | latch-address phase, BDIR=1 BC=1, DA_out = register number
// ADDR_GAP | inactive bus after the address phase
// WR       | write phase, BDIR=1 BC=0, DA_out = write data
// WR_GAP   | inactive bus closing a write
// RD       | read phase, BDIR=0 BC=1, DA_in captured on the last CE tick
// RD_GAP   | inactive bus closing a read
module psg_bus_master #(
    parameter int FIFO_DEPTH = 4,
    parameter int PULSE_LEN  = 2,
    parameter int GAP_LEN    = 1,
    parameter int SKIP_ADDR  = 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_ce,
    psg_bus_master_if.master   bus
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADDR     = 3'd1,
        S_ADDR_GAP = 3'd2,
        S_WR       = 3'd3,
        S_WR_GAP   = 3'd4,
        S_RD       = 3'd5,
        S_RD_GAP   = 3'd6
    } state_t;

    // Request FIFO: entry = {write, addr[3:0], data[7:0]}
    logic [12:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [12:0]   w_head;
    logic          w_head_write;
    logic [3:0]    w_head_addr;
    logic [7:0]    w_head_data;

    // Sequencing state
    state_t        r_state;
    state_t        w_next;
    logic [3:0]    r_cnt;
    logic [3:0]    w_load;
    logic          w_adv;
    logic          w_need_addr;

    // Working copy of the transaction in flight
    logic          r_wr;
    logic [3:0]    r_addr;
    logic [7:0]    r_data;

    // Last latched PSG address
    logic          r_cache_vld;
    logic [3:0]    r_cache_addr;

    logic          r_rsp_valid;
    logic [7:0]    r_rsp_data;
    logic [7:0]    r_da;

    logic          w_bdir;
    logic          w_bc;
    logic [7:0]    w_da;

    assign w_full       = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_empty      = (r_count == '0);
    assign w_push       = bus.req_valid && !w_full;
    assign w_pop        = (r_state == S_IDLE) && !w_empty;
    assign w_head       = r_mem[r_rptr];
    assign w_head_write = w_head[12];
    assign w_head_addr  = w_head[11:8];
    assign w_head_data  = w_head[7:0];

    // A repeated address can reuse the PSG's latched register number
    assign w_need_addr  = !((SKIP_ADDR != 0) && r_cache_vld && (w_head_addr == r_cache_addr));

    // Phase ends on the CE tick that would take the counter from 1 to 0
    assign w_adv        = (r_cnt == 4'd1) && i_ce;

    assign w_load       = ((w_next == S_ADDR) || (w_next == S_WR) || (w_next == S_RD))
                          ? 4'(PULSE_LEN) : 4'(GAP_LEN);

    // FIFO storage; contents need no reset since the pointers qualify them
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {bus.req_write, bus.req_addr, bus.req_data};
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // State register plus the registers that change on phase boundaries
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_wr         <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
            r_cache_vld  <= 1'b0;
            r_cache_addr <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
            r_da         <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_cnt <= w_load;
            end else if (i_ce && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (w_pop) begin
                r_wr   <= w_head_write;
                r_addr <= w_head_addr;
                r_data <= w_head_data;
            end

            if ((r_state == S_ADDR) && w_adv) begin
                r_cache_vld  <= 1'b1;
                r_cache_addr <= r_addr;
            end

            r_rsp_valid <= (r_state == S_RD) && w_adv;
            if ((r_state == S_RD) && w_adv) begin
                r_rsp_data <= bus.DA_in;
            end

            // Remembered so gap and idle states keep DA_out steady
            r_da <= w_da;
        end
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    if (w_need_addr) begin
                        w_next = S_ADDR;
                    end else if (w_head_write) begin
                        w_next = S_WR;
                    end else begin
                        w_next = S_RD;
                    end
                end
            end
            S_ADDR:     if (w_adv) w_next = S_ADDR_GAP;
            S_ADDR_GAP: if (w_adv) w_next = r_wr ? S_WR : S_RD;
            S_WR:       if (w_adv) w_next = S_WR_GAP;
            S_RD:       if (w_adv) w_next = S_RD_GAP;
            S_WR_GAP:   if (w_adv) w_next = S_IDLE;
            S_RD_GAP:   if (w_adv) w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    // Bus outputs decoded from the current state
    always_comb begin
        w_bdir = 1'b0;
        w_bc   = 1'b0;
        w_da   = r_da;
        case (r_state)
            S_ADDR: begin
                w_bdir = 1'b1;
                w_bc   = 1'b1;
                w_da   = {4'b0000, r_addr};
            end
            S_WR: begin
                w_bdir = 1'b1;
                w_da   = r_data;
            end
            S_RD: begin
                w_bc   = 1'b1;
                w_da   = 8'h00;
            end
            default: ;
        endcase
    end

    assign bus.BDIR      = w_bdir;
    assign bus.BC        = w_bc;
    assign bus.DA_out    = w_da;
    assign bus.req_ready = !w_full;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.busy      = !w_empty || (r_state != S_IDLE);

endmodule
